// File: rtl/status_display_if.sv
// Display-side bundle for status_display: the values to show and the
// multiplexed seven-segment drive that shows them.
interface status_display_if;
    logic [3:0] image_index;
    logic [7:0] blend_factor;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (output image_index, blend_factor, input seg, dp, an);
    modport slave  (input image_index, blend_factor, output seg, dp, an);
endinterface

// File: rtl/status_display.sv
// Four-digit multiplexed seven-segment driver: hex image index on the left digit,
// blend factor as three decimal digits (sequential double-dabble) on the right.
module status_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    status_display_if.slave  disp
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // One double-dabble iteration: BCD lives in [19:8], binary in [7:0].
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] a;
        // NOTE: blocking '=' is right here -- this is combinational scratch work
        // inside a function; registers below are only ever updated with '<='.
        a = s;
        for (int i = 0; i < 3; i++) begin
            if (a[8+4*i +: 4] >= 4'd5)
                a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    logic [3:0]    in_idx_q, snap_idx, hex_r;
    logic [7:0]    in_blend_q, snap_blend;
    logic [3:0]    bcd_hund, bcd_tens, bcd_ones;
    logic [19:0]   shreg;
    logic [2:0]    iter;
    state_t        state;

    logic [PW-1:0] presc;
    logic [1:0]    digit_sel, next_sel;
    logic [3:0]    an_r, next_an;
    logic [6:0]    seg_r, next_seg;
    logic          dp_r, next_dp;

    // Reset values match the button block's defaults so no conversion runs at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_idx_q   <= '0;
            in_blend_q <= 8'd128;
            snap_idx   <= '0;
            snap_blend <= 8'd128;
            state      <= IDLE;
            shreg      <= '0;
            iter       <= '0;
            hex_r      <= '0;
            bcd_hund   <= 4'd1;
            bcd_tens   <= 4'd2;
            bcd_ones   <= 4'd8;
        end else begin
            in_idx_q   <= disp.image_index;
            in_blend_q <= disp.blend_factor;
            case (state)
                IDLE: begin
                    if ({in_idx_q, in_blend_q} != {snap_idx, snap_blend}) begin
                        snap_idx   <= in_idx_q;
                        snap_blend <= in_blend_q;
                        shreg      <= {12'b0, in_blend_q};
                        iter       <= '0;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    shreg <= dabble_step(shreg);
                    iter  <= iter + 3'd1;
                    if (iter == 3'd7)
                        state <= DONE;
                end
                DONE: begin
                    hex_r    <= snap_idx;
                    bcd_hund <= shreg[19:16];
                    bcd_tens <= shreg[15:12];
                    bcd_ones <= shreg[11:8];
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Content of the digit the next scan tick will select, with leading-zero blanking.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned
        // (which would infer a latch).
        next_sel = digit_sel + 2'd1;
        next_an  = 4'b1111;
        next_seg = SEG_BLANK;
        next_dp  = 1'b1;
        case (next_sel)
            2'd0: begin
                next_an  = 4'b1110;
                next_seg = seg_code(bcd_ones);
            end
            2'd1: begin
                next_an = 4'b1101;
                if (bcd_hund != 4'd0 || bcd_tens != 4'd0)
                    next_seg = seg_code(bcd_tens);
            end
            2'd2: begin
                next_an = 4'b1011;
                if (bcd_hund != 4'd0)
                    next_seg = seg_code(bcd_hund);
            end
            default: begin
                next_an  = 4'b0111;
                next_seg = seg_code(hex_r);
                next_dp  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            digit_sel <= 2'd3;
            an_r      <= 4'b1111;
            seg_r     <= SEG_BLANK;
            dp_r      <= 1'b1;
        end else if (presc == PRESC_LAST) begin
            presc     <= '0;
            digit_sel <= next_sel;
            an_r      <= next_an;
            seg_r     <= next_seg;
            dp_r      <= next_dp;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign disp.an  = an_r;
    assign disp.seg = seg_r;
    assign disp.dp  = dp_r;

endmodule
